token_move_sequencer: RTL and testbench

Sequences the on-screen token animation between game_logic and ui_render. When game_logic publishes a new tile position (pos_valid), the block walks the active player's displayed tile one step at a time toward the target at a fixed step rate. After a settle delay it pulses turn_done back to game_logic. It owns the displayed positions fed to tile_position_mapper, so the renderer never jumps tiles.

---
 rtl/game_pkg.sv | 20 ++
 rtl/token_move_sequencer_if.sv | 31 +++
 rtl/tick_counter.sv | 28 ++
 rtl/token_move_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_token_move_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the token animation sequencer.
package game_pkg;

    localparam int unsigned NUM_TILES_C = 16;
    localparam int unsigned TILE_W_C    = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        SETTLE = 3'd2,
        DONE   = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

endpackage

// File: rtl/token_move_sequencer_if.sv
// Handshake between game_logic (master) and the token move sequencer (slave).
interface token_move_sequencer_if #(
    parameter int unsigned TILE_W = game_pkg::TILE_W_C
);

    logic              game_active;
    logic              pos_valid;
    logic              turn;
    logic [TILE_W-1:0] p1_target;
    logic [TILE_W-1:0] p2_target;
    logic              winner_valid;

    logic [TILE_W-1:0] p1_disp;
    logic [TILE_W-1:0] p2_disp;
    logic              mover_id;
    logic              busy;
    logic              step_pulse;
    logic              turn_done;
    logic              overrun;

    modport master (
        output game_active, pos_valid, turn, p1_target, p2_target, winner_valid,
        input  p1_disp, p2_disp, mover_id, busy, step_pulse, turn_done, overrun
    );

    modport slave (
        input  game_active, pos_valid, turn, p1_target, p2_target, winner_valid,
        output p1_disp, p2_disp, mover_id, busy, step_pulse, turn_done, overrun
    );

endinterface

// File: rtl/tick_counter.sv
// Terminal-count counter; tc_c flags the cycle whose edge wraps the count to zero.
module tick_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    assign tc_c = enable && !clear && (count == term);

    // Count while enabled, wrap on terminal value, hold at zero while cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/token_move_sequencer.sv
// Walks the moving player's displayed tile toward its target one step at a time,
// waits a settle delay, then pulses turn_done back to game_logic.
module token_move_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_TILES    = NUM_TILES_C,
    parameter int unsigned TILE_W       = TILE_W_C,
    parameter int unsigned STEP_TICKS   = 25_000_000,
    parameter int unsigned SETTLE_TICKS = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    token_move_sequencer_if.slave bus
);

    localparam int unsigned MAX_TICKS = (STEP_TICKS > SETTLE_TICKS) ? STEP_TICKS : SETTLE_TICKS;
    localparam int unsigned CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] STEP_TERM   = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_TICKS - 1);

    seq_state_t        state, state_n;
    player_t           mover, mover_n;
    logic [TILE_W-1:0] p1_disp, p1_disp_n;
    logic [TILE_W-1:0] p2_disp, p2_disp_n;
    logic [TILE_W-1:0] tgt, tgt_n;
    logic [TILE_W-1:0] idle_tgt, idle_tgt_n;
    logic              busy, busy_n;
    logic              step_pulse, step_pulse_n;
    logic              turn_done, turn_done_n;
    logic              overrun, overrun_n;

    logic              cnt_en_c;
    logic              cnt_clr_c;
    logic [CNT_W-1:0]  cnt_term_c;
    logic              tc_c;
    logic [TILE_W-1:0] mover_disp_c;
    logic [TILE_W-1:0] mover_disp_next_c;

    // Out-of-range targets land on the last tile.
    function automatic logic [TILE_W-1:0] clamp_tile(input logic [TILE_W-1:0] t);
        if (32'(t) >= NUM_TILES) begin
            return TILE_W'(NUM_TILES - 1);
        end
        return t;
    endfunction

    // One shared counter times both the step interval and the settle hold.
    always_comb begin
        cnt_en_c   = bus.game_active && ((state == STEP) || (state == SETTLE));
        cnt_clr_c  = !cnt_en_c;
        cnt_term_c = (state == STEP) ? STEP_TERM : SETTLE_TERM;
    end

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clr_c),
        .enable  (cnt_en_c),
        .term    (cnt_term_c),
        .tc_c    (tc_c)
    );

    // Mover's current tile and the tile one step closer to its target.
    always_comb begin
        mover_disp_c      = (mover == P2) ? p2_disp : p1_disp;
        mover_disp_next_c = (tgt > mover_disp_c) ? mover_disp_c + TILE_W'(1)
                                                 : mover_disp_c - TILE_W'(1);
    end

    // State and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mover      <= P1;
            p1_disp    <= '0;
            p2_disp    <= '0;
            tgt        <= '0;
            idle_tgt   <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            turn_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            mover      <= mover_n;
            p1_disp    <= p1_disp_n;
            p2_disp    <= p2_disp_n;
            tgt        <= tgt_n;
            idle_tgt   <= idle_tgt_n;
            busy       <= busy_n;
            step_pulse <= step_pulse_n;
            turn_done  <= turn_done_n;
            overrun    <= overrun_n;
        end
    end

    // Next-state and next-output logic; leaving the game overrides everything.
    always_comb begin
        state_n      = state;
        mover_n      = mover;
        p1_disp_n    = p1_disp;
        p2_disp_n    = p2_disp;
        tgt_n        = tgt;
        idle_tgt_n   = idle_tgt;
        step_pulse_n = 1'b0;
        turn_done_n  = 1'b0;
        overrun_n    = overrun;

        if (!bus.game_active) begin
            state_n   = IDLE;
            p1_disp_n = '0;
            p2_disp_n = '0;
            overrun_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.pos_valid) begin
                        mover_n = player_t'(bus.turn);
                        if (bus.turn) begin
                            tgt_n      = clamp_tile(bus.p2_target);
                            idle_tgt_n = clamp_tile(bus.p1_target);
                            state_n    = (tgt_n != p2_disp) ? STEP : SETTLE;
                        end else begin
                            tgt_n      = clamp_tile(bus.p1_target);
                            idle_tgt_n = clamp_tile(bus.p2_target);
                            state_n    = (tgt_n != p1_disp) ? STEP : SETTLE;
                        end
                    end
                end
                STEP: begin
                    if (bus.pos_valid) begin
                        overrun_n = 1'b1;
                    end
                    if (tc_c) begin
                        step_pulse_n = 1'b1;
                        if (mover == P2) begin
                            p2_disp_n = mover_disp_next_c;
                        end else begin
                            p1_disp_n = mover_disp_next_c;
                        end
                        if (mover_disp_next_c == tgt) begin
                            state_n = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (bus.pos_valid) begin
                        overrun_n = 1'b1;
                    end
                    if (tc_c) begin
                        state_n     = DONE;
                        turn_done_n = 1'b1;
                        // The idle player may have been displaced by an event.
                        if (mover == P2) begin
                            p1_disp_n = idle_tgt;
                        end else begin
                            p2_disp_n = idle_tgt;
                        end
                    end
                end
                DONE: begin
                    if (bus.pos_valid) begin
                        overrun_n = 1'b1;
                    end
                    state_n = bus.winner_valid ? FINISH : IDLE;
                end
                FINISH: begin
                    state_n = FINISH;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n == STEP) || (state_n == SETTLE) || (state_n == DONE);
    end

    assign bus.p1_disp    = p1_disp;
    assign bus.p2_disp    = p2_disp;
    assign bus.mover_id   = mover;
    assign bus.busy       = busy;
    assign bus.step_pulse = step_pulse;
    assign bus.turn_done  = turn_done;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_token_move_sequencer.sv
// Bench for token_move_sequencer: timeline model plus directed scenarios.
module tb_token_move_sequencer;

    localparam int unsigned NT = 16;
    localparam int unsigned TW = 5;
    localparam int unsigned ST = 4;
    localparam int unsigned SE = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    initial forever #5 clk = ~clk;

    token_move_sequencer_if #(.TILE_W(TW)) bus();

    token_move_sequencer #(
        .NUM_TILES    (NT),
        .TILE_W       (TW),
        .STEP_TICKS   (ST),
        .SETTLE_TICKS (SE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a move accepted at edge k is a timeline of edges k+e.
    int cyc = 0;
    int m_mode = 0;              // 0 idle, 1 moving, 2 finished
    int m_disp[2] = '{0, 0};
    int m_mover = 0, m_start = 0, m_tgt = 0, m_other = 0, m_tacc = 0, m_d = 0, m_dir = 1;
    int e_step = 0, e_done = 0, e_busy = 0, e_over = 0, e_mover = 0;

    function automatic int clamp(input int t);
        return (t >= int'(NT)) ? int'(NT) - 1 : t;
    endfunction

    initial forever begin
        int e, tt, n;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_mode = 0; m_disp = '{0, 0};
            e_step = 0; e_done = 0; e_busy = 0; e_over = 0; e_mover = 0;
        end else begin
            cyc++;
            e_step = 0;
            e_done = 0;
            if (!bus.game_active) begin
                m_mode = 0; m_disp = '{0, 0}; e_over = 0; e_busy = 0;
            end else if (m_mode == 0) begin
                if (bus.pos_valid) begin
                    m_mover = int'(bus.turn);
                    m_tgt   = clamp(int'(m_mover ? bus.p2_target : bus.p1_target));
                    m_other = clamp(int'(m_mover ? bus.p1_target : bus.p2_target));
                    m_start = m_disp[m_mover];
                    m_d     = (m_tgt >= m_start) ? m_tgt - m_start : m_start - m_tgt;
                    m_dir   = (m_tgt >= m_start) ? 1 : -1;
                    m_tacc  = cyc;
                    e_mover = m_mover;
                    e_busy  = 1;
                    m_mode  = 1;
                end
            end else if (m_mode == 1) begin
                e  = cyc - m_tacc;
                tt = m_d * int'(ST) + int'(SE);
                if (bus.pos_valid) e_over = 1;
                if (e <= tt) begin
                    n = e / int'(ST);
                    if (n > m_d) n = m_d;
                    m_disp[m_mover] = m_start + m_dir * n;
                    e_step = (e % int'(ST) == 0 && n >= 1 && e <= m_d * int'(ST)) ? 1 : 0;
                    if (e == tt) begin
                        e_done = 1;
                        m_disp[1 - m_mover] = m_other;
                    end
                    e_busy = 1;
                end else begin
                    e_busy = 0;
                    m_mode = bus.winner_valid ? 2 : 0;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            check("p1_disp",    int'(bus.p1_disp),    m_disp[0]);
            check("p2_disp",    int'(bus.p2_disp),    m_disp[1]);
            check("mover_id",   int'(bus.mover_id),   e_mover);
            check("busy",       int'(bus.busy),       e_busy);
            check("step_pulse", int'(bus.step_pulse), e_step);
            check("turn_done",  int'(bus.turn_done),  e_done);
            check("overrun",    int'(bus.overrun),    e_over);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; pos_valid is sampled at the following posedge (edge k).
    task automatic pulse_pos(input logic t, input int t1, input int t2);
        bus.turn      = t;
        bus.p1_target = TW'(t1);
        bus.p2_target = TW'(t2);
        bus.pos_valid = 1'b1;
        @(negedge clk);
        bus.pos_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.game_active  = 1'b0;
        bus.pos_valid    = 1'b0;
        bus.turn         = 1'b0;
        bus.p1_target    = '0;
        bus.p2_target    = '0;
        bus.winner_valid = 1'b0;
        wait_cyc(3);
        check("rst_p1",   int'(bus.p1_disp), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.turn_done), 0);
        check("rst_over", int'(bus.overrun), 0);
        reset_n = 1'b1;
        bus.game_active = 1'b1;
        wait_cyc(2);

        // Reset in the middle of a move.
        pulse_pos(1'b0, 3, 0);
        wait_cyc(5);
        check("mid_p1", int'(bus.p1_disp), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_p1",   int'(bus.p1_disp), 0);
        check("async_busy", int'(bus.busy), 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(1);

        // P1 forward 0 -> 3.
        pulse_pos(1'b0, 3, 0);
        wait_cyc(3);
        check("a_k3_step", int'(bus.step_pulse), 0);
        wait_cyc(1);
        check("a_k4_step", int'(bus.step_pulse), 1);
        check("a_k4_p1",   int'(bus.p1_disp), 1);
        wait_cyc(4);
        check("a_k8_p1",   int'(bus.p1_disp), 2);
        wait_cyc(4);
        check("a_k12_p1",  int'(bus.p1_disp), 3);
        check("a_k12_step", int'(bus.step_pulse), 1);
        wait_cyc(3);
        check("a_k15_done", int'(bus.turn_done), 1);
        check("a_k15_busy", int'(bus.busy), 1);
        wait_cyc(1);
        check("a_k16_done", int'(bus.turn_done), 0);
        check("a_k16_busy", int'(bus.busy), 0);

        // P2 to tile 5, then penalty back to 2.
        pulse_pos(1'b1, 3, 5);
        wait_cyc(25);
        check("b_p2_at5", int'(bus.p2_disp), 5);
        pulse_pos(1'b1, 3, 2);
        wait_cyc(4);
        check("b_p2_4", int'(bus.p2_disp), 4);
        wait_cyc(4);
        check("b_p2_3", int'(bus.p2_disp), 3);
        wait_cyc(4);
        check("b_p2_2", int'(bus.p2_disp), 2);
        wait_cyc(3);
        check("b_done", int'(bus.turn_done), 1);
        check("b_p1",   int'(bus.p1_disp), 3);
        wait_cyc(1);

        // Out-of-range target clamps to the last tile.
        pulse_pos(1'b0, 20, 2);
        wait_cyc(51);
        check("c_done",  int'(bus.turn_done), 1);
        check("c_p1_15", int'(bus.p1_disp), 15);
        wait_cyc(1);
        check("c_busy",  int'(bus.busy), 0);

        // Zero distance, plus a second pos_valid while busy.
        pulse_pos(1'b0, 15, 2);
        pulse_pos(1'b1, 0, 9);
        check("d_over",  int'(bus.overrun), 1);
        wait_cyc(2);
        check("d_done",  int'(bus.turn_done), 1);
        check("d_step",  int'(bus.step_pulse), 0);
        check("d_p2",    int'(bus.p2_disp), 2);
        wait_cyc(3);
        check("d_over_sticky", int'(bus.overrun), 1);

        bus.game_active = 1'b0;
        wait_cyc(1);
        check("g_p1",   int'(bus.p1_disp), 0);
        check("g_over", int'(bus.overrun), 0);
        bus.game_active = 1'b1;
        wait_cyc(1);

        // Winning move ends in FINISH; idle player snaps to its target.
        bus.winner_valid = 1'b1;
        pulse_pos(1'b1, 7, 2);
        wait_cyc(11);
        check("f_done", int'(bus.turn_done), 1);
        check("f_p1",   int'(bus.p1_disp), 7);
        check("f_p2",   int'(bus.p2_disp), 2);
        wait_cyc(1);
        check("f_busy", int'(bus.busy), 0);
        pulse_pos(1'b0, 10, 3);
        wait_cyc(5);
        check("f_over", int'(bus.overrun), 0);
        check("f_hold", int'(bus.p1_disp), 7);
        bus.winner_valid = 1'b0;
        bus.game_active  = 1'b0;
        wait_cyc(1);
        check("f_exit_p1", int'(bus.p1_disp), 0);
        check("f_exit_p2", int'(bus.p2_disp), 0);
        bus.game_active = 1'b1;
        wait_cyc(1);

        // pos_valid during the DONE cycle is dropped and flagged.
        pulse_pos(1'b0, 1, 0);
        wait_cyc(7);
        check("h_done", int'(bus.turn_done), 1);
        pulse_pos(1'b1, 0, 4);
        check("h_over", int'(bus.overrun), 1);
        check("h_busy", int'(bus.busy), 0);
        check("h_p2",   int'(bus.p2_disp), 0);
        wait_cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
